tc_bank: RTL and testbench

Parametrised multi-channel timer/counter bank: the successor to the fixed two-instance timer arrangement on the MEM-stage device bus. It provides NUM_CH independent down-counters behind one bus slave, each with one-shot or auto-reload mode, a maskable pending flag, and a shared tick prescaler. Per-channel IRQs are also OR-reduced onto one line for the CP0 interrupt input.

---
 rtl/tc_bank.sv | 77 +++++++
 tb/tb_tc_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_bank.sv
// tc_bank: NUM_CH independent down-counter timers with a shared tick prescaler
// behind one word-addressed bus slave; per-channel IRQs plus their OR.
module tc_bank #(
    parameter int NUM_CH = 2,
    parameter int DIV    = 1,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);
    localparam int CW = ADDR_W - 2;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    logic [PW-1:0] p;
    logic          tick;
    logic [CW-1:0] ch;
    logic [31:0]   rd [2**CW];
    assign tick    = p == PW'(DIV - 1);
    assign ch      = Addr[ADDR_W-1:2];
    assign Dout    = rd[ch];
    assign IRQ_any = |IRQ;
    always_ff @(posedge clk or posedge reset)
        if (reset) p <= '0;
        else p <= tick ? '0 : p + 1'b1;
    // Every decodable channel slot gets a read word so Dout needs no range check.
    for (genvar c = 0; c < 2**CW; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            state_t      state, state_nx;
            logic [3:0]  ctrl;
            logic [31:0] preset, count;
            logic        pend, sel, wr_ctrl, wr_pre, wr_stat, reload, set_p;
            assign sel     = WE && int'(ch) == c;
            assign wr_ctrl = sel && Addr[1:0] == 2'd0;
            assign wr_pre  = sel && Addr[1:0] == 2'd1;
            assign wr_stat = sel && Addr[1:0] == 2'd3 && Din[0];
            assign reload  = ctrl[2:1] == 2'b01;
            always_comb begin
                set_p    = state == CNT && ctrl[0] && count == '0;
                state_nx = state == IDLE ? (ctrl[0] ? LOAD : IDLE) :
                           state == LOAD ? CNT :
                           state == CNT  ? (!ctrl[0] ? IDLE : set_p ? INT : CNT) :
                           (reload ? LOAD : IDLE);
            end
            always_ff @(posedge clk or posedge reset)
                if (reset) state <= IDLE;
                else state <= state_nx;
            // A CTRL write outranks the one-shot EN clear; a pending set outranks any clear.
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    ctrl   <= '0;
                    preset <= '0;
                    count  <= '0;
                    pend   <= 1'b0;
                end else begin
                    if (wr_ctrl) ctrl <= Din[3:0];
                    else if (state == INT && !reload) ctrl[0] <= 1'b0;
                    if (wr_pre) preset <= Din;
                    if (state == LOAD) count <= preset;
                    else if (state == CNT && ctrl[0] && !set_p && tick) count <= count - 32'd1;
                    if (set_p) pend <= 1'b1;
                    else if (wr_ctrl || wr_stat) pend <= 1'b0;
                end
            assign rd[c] = Addr[1:0] == 2'd0 ? {28'd0, ctrl} :
                           Addr[1:0] == 2'd1 ? preset :
                           Addr[1:0] == 2'd2 ? count : {31'd0, pend};
            assign IRQ[c] = pend & ctrl[3];
        end else begin : g_off
            assign rd[c] = '0;
        end
    end
endmodule

// File: tb/tb_tc_bank.sv
// tb_tc_bank: two four-channel banks (DIV=1 and DIV=4) on one bus, checked every
// cycle against a behavioural model, with directed scenarios and random traffic.
module tb_tc_bank;
    localparam int NC = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;
    logic          clk = 1'b0, reset = 1'b1, WE = 1'b0;
    logic [5:0]    Addr = '0;
    logic [31:0]   Din = '0, dout0, dout1;
    logic [NC-1:0] irq0, irq1;
    logic          any0, any1;
    int checks = 0, errors = 0;
    int dv [2] = '{1, 4};
    int m_p [2];
    logic [3:0]  m_ctrl [2][NC];
    logic [31:0] m_pre [2][NC];
    logic [31:0] m_cnt [2][NC];
    logic        m_pend [2][NC];
    int          m_ph [2][NC];

    tc_bank #(.NUM_CH(NC), .DIV(1), .ADDR_W(6)) u0 (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(dout0), .IRQ(irq0), .IRQ_any(any0));
    tc_bank #(.NUM_CH(NC), .DIV(4), .ADDR_W(6)) u1 (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(dout1), .IRQ(irq1), .IRQ_any(any1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_p[i] = 0;
            for (int c = 0; c < NC; c++) begin
                m_ctrl[i][c] = '0;
                m_pre[i][c]  = '0;
                m_cnt[i][c]  = '0;
                m_pend[i][c] = 1'b0;
                m_ph[i][c]   = P_IDLE;
            end
        end
    endtask

    // Advance the model by one clock using the bus inputs present at the edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic tk;
            tk = m_p[i] == dv[i] - 1;
            m_p[i] = tk ? 0 : m_p[i] + 1;
            for (int c = 0; c < NC; c++) begin
                logic hit, wc, en, rl, setp;
                logic [3:0] nc;
                hit  = WE && int'(Addr[5:2]) == c;
                wc   = hit && Addr[1:0] == 2'd0;
                en   = m_ctrl[i][c][0];
                rl   = m_ctrl[i][c][2:1] == 2'b01;
                setp = 1'b0;
                nc   = m_ctrl[i][c];
                if (m_ph[i][c] == P_IDLE) begin
                    if (en) m_ph[i][c] = P_LOAD;
                end else if (m_ph[i][c] == P_LOAD) begin
                    m_cnt[i][c] = m_pre[i][c];
                    m_ph[i][c] = P_CNT;
                end else if (m_ph[i][c] == P_CNT) begin
                    if (!en) m_ph[i][c] = P_IDLE;
                    else if (m_cnt[i][c] == 0) begin
                        m_ph[i][c] = P_INT;
                        setp = 1'b1;
                    end else if (tk) m_cnt[i][c] = m_cnt[i][c] - 1;
                end else begin
                    if (!rl) nc[0] = 1'b0;
                    m_ph[i][c] = rl ? P_LOAD : P_IDLE;
                end
                if (wc) nc = Din[3:0];
                m_ctrl[i][c] = nc;
                if (hit && Addr[1:0] == 2'd1) m_pre[i][c] = Din;
                if (setp) m_pend[i][c] = 1'b1;
                else if (wc || (hit && Addr[1:0] == 2'd3 && Din[0])) m_pend[i][c] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] mread(input int i, input logic [5:0] a);
        int c;
        c = int'(a[5:2]);
        if (c >= NC) return 32'd0;
        case (a[1:0])
            2'd0:    return {28'd0, m_ctrl[i][c]};
            2'd1:    return m_pre[i][c];
            2'd2:    return m_cnt[i][c];
            default: return {31'd0, m_pend[i][c]};
        endcase
    endfunction

    function automatic logic [NC-1:0] mirq(input int i);
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = m_pend[i][c] & m_ctrl[i][c][3];
        return r;
    endfunction

    task automatic compare_all();
        chk("u0_dout", dout0, mread(0, Addr));
        chk("u0_irq", 32'(irq0), 32'(mirq(0)));
        chk("u0_irq_any", 32'(any0), 32'(|mirq(0)));
        chk("u1_dout", dout1, mread(1, Addr));
        chk("u1_irq", 32'(irq1), 32'(mirq(1)));
        chk("u1_irq_any", 32'(any1), 32'(|mirq(1)));
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus(input logic [5:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        tick_cycle();
        WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic do_reset();
        WE = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        chk("por_dout", dout0, 32'd0);
        chk("por_irq_any", 32'(any0), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a count
        bus(6'd1, 32'd10);
        bus(6'd0, 32'h1);
        Addr = 6'd2;
        idle(7);
        chk("mid_count", dout0, 32'd5);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_count", dout0, 32'd0);
        chk("rst_irq", 32'(irq0), 32'd0);
        Addr = 6'd0;
        #1;
        chk("rst_ctrl", dout0, 32'd0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // One-shot ch0, PRESET=4
        bus(6'd1, 32'd4);
        bus(6'd0, 32'h9);
        Addr = 6'd0;
        for (int k = 1; k <= 8; k++) begin
            tick_cycle();
            if (k == 6) chk("os_irq_e6", 32'(irq0[0]), 32'd0);
            if (k == 7) chk("os_irq_e7", 32'(irq0[0]), 32'd1);
            if (k == 7) chk("os_div4_not_yet", 32'(irq1[0]), 32'd0);
            if (k == 8) chk("os_ctrl_e8", dout0, 32'h8);
        end
        tick_cycle();
        bus(6'd3, 32'd1);
        chk("os_irq_cleared", 32'(irq0[0]), 32'd0);
        Addr = 6'd2;
        tick_cycle();
        chk("os_count_zero", dout0, 32'd0);

        // Auto-reload ch1, PRESET=3
        bus(6'd5, 32'd3);
        bus(6'd4, 32'hB);
        Addr = 6'd6;
        for (int k = 1; k <= 6; k++) begin
            tick_cycle();
            if (k == 5) chk("ar_irq_e5", 32'(irq0[1]), 32'd0);
            if (k == 6) chk("ar_irq_e6", 32'(irq0[1]), 32'd1);
        end
        bus(6'd7, 32'd1);
        Addr = 6'd6;
        tick_cycle();
        chk("ar_reload_e8", dout0, 32'd3);
        for (int k = 9; k <= 12; k++) begin
            tick_cycle();
            if (k == 11) chk("ar_irq_e11", 32'(irq0[1]), 32'd0);
            if (k == 12) chk("ar_irq_e12", 32'(irq0[1]), 32'd1);
        end
        bus(6'd4, 32'h0);
        idle(3);

        // Auto-reload ch1 with IRQ masked
        bus(6'd4, 32'h3);
        Addr = 6'd7;
        idle(6);
        chk("im0_status", dout0, 32'd1);
        chk("im0_irq", 32'(irq0[1]), 32'd0);
        bus(6'd4, 32'h0);
        idle(3);

        // Status clear in the same cycle as expiry; read-only and out-of-range addresses
        bus(6'd9, 32'd2);
        bus(6'd8, 32'h9);
        idle(4);
        bus(6'd11, 32'd1);
        chk("setclr_irq", 32'(irq0[2]), 32'd1);
        Addr = 6'd11;
        tick_cycle();
        chk("setclr_status", dout0, 32'd1);
        bus(6'd10, 32'h55);
        Addr = 6'd10;
        tick_cycle();
        chk("count_ro", dout0, 32'd0);
        bus(6'd16, 32'hF);
        Addr = 6'd16;
        tick_cycle();
        chk("oob_read", dout0, 32'd0);
        bus(6'd11, 32'd1);
        chk("setclr_done", 32'(irq0[2]), 32'd0);

        // Four channels expiring on the same edge
        bus(6'd1, 32'd5);
        bus(6'd5, 32'd4);
        bus(6'd9, 32'd3);
        bus(6'd13, 32'd2);
        bus(6'd0, 32'hB);
        bus(6'd4, 32'hB);
        bus(6'd8, 32'hB);
        bus(6'd12, 32'hB);
        for (int k = 4; k <= 8; k++) begin
            tick_cycle();
            if (k == 7) chk("all_irq_e7", 32'(irq0), 32'h0);
            if (k == 8) chk("all_irq_e8", 32'(irq0), 32'hF);
            if (k == 8) chk("all_any_e8", 32'(any0), 32'd1);
        end
        bus(6'd11, 32'd1);
        chk("all_clr_ch2", 32'(irq0), 32'hB);
        for (int c = 0; c < NC; c++) bus(6'(4 * c), 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else begin
                WE   = $urandom_range(0, 3) == 0;
                Addr = $urandom_range(0, 7) == 0 ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
                Din  = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 12));
                tick_cycle();
            end
        end
        WE = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
